// File: rtl/pc_branch_sequencer_if.sv
// Fetch-side bundle between the EX-stage branch logic, the PC sequencer and
// instruction memory. The master drives EX/IMEM inputs; the sequencer is the slave.
interface pc_branch_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       bs;
    logic             ps;
    logic             z;
    logic             br_valid;
    logic [WIDTH-1:0] bra;
    logic [WIDTH-1:0] raa;
    logic             stall;
    logic             imem_ready;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             flush;
    logic             redirect;

    modport master (
        output bs, ps, z, br_valid, bra, raa, stall, imem_ready,
        input  pc, pc_valid, flush, redirect
    );

    modport slave (
        input  bs, ps, z, br_valid, bra, raa, stall, imem_ready,
        output pc, pc_valid, flush, redirect
    );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter owner and next-PC branch sequencer with stall hold and flush.
// Optional taken-branch performance counter enabled by defining PC_SEQ_PERF_EN.
module pc_branch_sequencer #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               FLUSH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_branch_sequencer_if.slave  io_bus
`ifdef PC_SEQ_PERF_EN
    ,
    input  logic                  cnt_clr,
    output logic [15:0]           taken_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH
    } state_e;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_flush;
    logic             r_redirect;
    logic [2:0]       r_flush_cnt;

    logic             w_cond;
    logic             w_taken;
    logic [WIDTH-1:0] w_target;

    always_comb begin
        w_cond   = 1'b0;
        w_target = io_bus.bra;
        case (io_bus.bs)
            2'b00: w_cond = 1'b0;
            2'b01: w_cond = io_bus.z ^ io_bus.ps;
            2'b10: begin
                w_cond   = 1'b1;
                w_target = io_bus.raa;
            end
            default: w_cond = 1'b1;
        endcase
    end

    // Only FETCH accepts branches; in FLUSH the EX contents belong to squashed work.
    assign w_taken = (r_state == S_FETCH) && io_bus.br_valid && !io_bus.stall
                     && !r_flush && w_cond;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_pc_valid  <= 1'b0;
            r_flush     <= 1'b0;
            r_redirect  <= 1'b0;
            r_flush_cnt <= 3'd0;
        end else if (r_state == S_IDLE) begin
            r_state    <= S_FETCH;
            r_pc_valid <= 1'b1;
        end else if (io_bus.stall) begin
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
        end else if (w_taken) begin
            r_pc        <= w_target;
            r_redirect  <= 1'b1;
            r_flush     <= 1'b1;
            r_flush_cnt <= FLUSH_LOAD;
            r_state     <= S_FLUSH;
        end else begin
            r_redirect <= 1'b0;
            if (io_bus.imem_ready) begin
                r_pc <= r_pc + WIDTH'(1);
            end
            if (r_state == S_FLUSH) begin
                // Counter holds across stalls, so flush covers FLUSH_DEPTH unstalled cycles.
                if (r_flush_cnt == 3'd0) begin
                    r_state <= S_FETCH;
                    r_flush <= 1'b0;
                end else begin
                    r_flush_cnt <= r_flush_cnt - 3'd1;
                    r_flush     <= 1'b1;
                end
            end else begin
                r_flush <= 1'b0;
            end
        end
    end

    assign io_bus.pc       = r_pc;
    assign io_bus.pc_valid = r_pc_valid;
    assign io_bus.flush    = r_flush;
    assign io_bus.redirect = r_redirect;

`ifdef PC_SEQ_PERF_EN
    logic [15:0] r_taken_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= 16'd0;
        end else if (cnt_clr) begin
            r_taken_cnt <= 16'd0;
        end else if (w_taken && (r_taken_cnt != 16'hFFFF)) begin
            r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

    assign taken_cnt = r_taken_cnt;
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed self-checking bench for pc_branch_sequencer; expected outputs are queued
// as each step is driven and popped when the DUT output is sampled.
module tb_pc_branch_sequencer;

    localparam logic [31:0] BRA = 32'hBBBBBBBB;
    localparam logic [31:0] RAA = 32'hAAAAAAAA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_branch_sequencer_if #(.WIDTH(32)) bus ();

`ifdef PC_SEQ_PERF_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] taken_cnt;
`endif

    pc_branch_sequencer #(
        .WIDTH       (32),
        .RESET_PC    (32'h00000000),
        .FLUSH_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_bus    (bus.slave)
`ifdef PC_SEQ_PERF_EN
        ,
        .cnt_clr   (cnt_clr),
        .taken_cnt (taken_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pv;
        logic        fl;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check({e.tag, ".pc"},       bus.pc,       e.pc);
        check({e.tag, ".pc_valid"}, {31'b0, bus.pc_valid}, {31'b0, e.pv});
        check({e.tag, ".flush"},    {31'b0, bus.flush},    {31'b0, e.fl});
        check({e.tag, ".redirect"}, {31'b0, bus.redirect}, {31'b0, e.rd});
    endtask

    task automatic check_now(input string tag, input logic [31:0] pc,
                             input logic pv, input logic fl, input logic rd);
        exp_t e;
        e = '{tag, pc, pv, fl, rd};
        check_outputs(e);
    endtask

    // Queue the expectation, advance one edge, then compare the registered outputs.
    task automatic step(input string tag, input logic [31:0] pc,
                        input logic pv, input logic fl, input logic rd);
        exp_t e;
        e = '{tag, pc, pv, fl, rd};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(e);
    endtask

    task automatic drive(input logic [1:0] bs, input logic ps, input logic z, input logic bv);
        bus.bs       = bs;
        bus.ps       = ps;
        bus.z        = z;
        bus.br_valid = bv;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        bus.bra        = BRA;
        bus.raa        = RAA;
        bus.stall      = 1'b0;
        bus.imem_ready = 1'b1;
        #1;
        check_now("rst_async", 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_now("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
    endtask

    function automatic logic model_taken(input logic [1:0] bs, input logic ps, input logic z);
        case (bs)
            2'b00:   return 1'b0;
            2'b01:   return (z && !ps) || (!z && ps);
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic [1:0]  s_bs;
        logic        s_ps;
        logic        s_z;
        logic [31:0] tgt;
        string       t;

        // 1. reset then sequential fetch
        do_reset();
        step("seq0", 32'd0, 1'b1, 1'b0, 1'b0);
        step("seq1", 32'd1, 1'b1, 1'b0, 1'b0);
        step("seq2", 32'd2, 1'b1, 1'b0, 1'b0);
        step("seq3", 32'd3, 1'b1, 1'b0, 1'b0);

        // 2. all 16 {z,ps,bs} combinations from a fresh reset
        for (int i = 0; i < 16; i++) begin
            s_z  = i[3];
            s_ps = i[2];
            s_bs = i[1:0];
            t    = $sformatf("sweep_z%0d_ps%0d_bs%0d", s_z, s_ps, s_bs);
            tgt  = (s_bs == 2'b10) ? RAA : BRA;
            do_reset();
            step({t, "_c0"}, 32'd0, 1'b1, 1'b0, 1'b0);
            drive(s_bs, s_ps, s_z, 1'b1);
            if (model_taken(s_bs, s_ps, s_z)) begin
                step({t, "_c1"}, tgt, 1'b1, 1'b1, 1'b1);
                drive(2'b00, 1'b0, 1'b0, 1'b0);
                step({t, "_c2"}, tgt + 32'd1, 1'b1, 1'b1, 1'b0);
                step({t, "_c3"}, tgt + 32'd2, 1'b1, 1'b0, 1'b0);
            end else begin
                step({t, "_c1"}, 32'd1, 1'b1, 1'b0, 1'b0);
                drive(2'b00, 1'b0, 1'b0, 1'b0);
                step({t, "_c2"}, 32'd2, 1'b1, 1'b0, 1'b0);
                step({t, "_c3"}, 32'd3, 1'b1, 1'b0, 1'b0);
            end
        end

        // 3. branches in the flush shadow are ignored
        do_reset();
        step("sh_pc0", 32'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) step($sformatf("sh_pc%0d", k), k, 1'b1, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0, 1'b1);
        step("sh_jump", BRA, 1'b1, 1'b1, 1'b1);
        drive(2'b10, 1'b0, 1'b0, 1'b1);
        step("sh_ign1", BRA + 32'd1, 1'b1, 1'b1, 1'b0);
        step("sh_ign2", BRA + 32'd2, 1'b1, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b0, 1'b0);

        // 4. stall holds pc and defers the redirect; stall in FLUSH extends flush
        do_reset();
        step("st_pc0", 32'd0, 1'b1, 1'b0, 1'b0);
        step("st_pc1", 32'd1, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b1;
        drive(2'b11, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step($sformatf("st_hold%0d", k), 32'd1, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b0;
        step("st_jump", BRA, 1'b1, 1'b1, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        bus.stall = 1'b1;
        step("st_fl_hold", BRA, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b0;
        step("st_fl2", BRA + 32'd1, 1'b1, 1'b1, 1'b0);
        step("st_done", BRA + 32'd2, 1'b1, 1'b0, 1'b0);

        // 5. wrap at all-ones with imem backpressure
        do_reset();
        bus.bra = 32'hFFFFFFFE;
        step("wr_pc0", 32'd0, 1'b1, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0, 1'b1);
        step("wr_jump", 32'hFFFFFFFE, 1'b1, 1'b1, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        step("wr_ff", 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        bus.imem_ready = 1'b0;
        step("wr_bp", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        bus.imem_ready = 1'b1;
        step("wr_zero", 32'h00000000, 1'b1, 1'b0, 1'b0);

        // 6. asynchronous reset during the second flush cycle
        do_reset();
        step("ar_pc0", 32'd0, 1'b1, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0, 1'b1);
        step("ar_jump", BRA, 1'b1, 1'b1, 1'b1);
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        step("ar_fl2", BRA + 32'd1, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("ar_async", 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef PC_SEQ_PERF_EN
        do_reset();
        step("pf_pc0", 32'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b0, 1'b0, 1'b1);
            step($sformatf("pf_jump%0d", k), BRA, 1'b1, 1'b1, 1'b1);
            drive(2'b00, 1'b0, 1'b0, 1'b0);
            step($sformatf("pf_fl%0d", k), BRA + 32'd1, 1'b1, 1'b1, 1'b0);
            step($sformatf("pf_seq%0d", k), BRA + 32'd2, 1'b1, 1'b0, 1'b0);
        end
        check("taken_cnt3", {16'b0, taken_cnt}, 32'd3);
        cnt_clr = 1'b1;
        step("pf_clr", BRA + 32'd3, 1'b1, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        check("taken_cnt_clr", {16'b0, taken_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
Owns the program counter and sequences the next-PC branch mux for the pipelined RISC core.
- Resolves the EX-stage branch decision from BS/PS/Z: PC+1, conditional BrA, register target RAA, or unconditional BrA.
- Drives the fetch request, with stall hold and pipeline flush.
- Sits between the EX-stage branch logic and instruction memory; replaces the free-standing next-PC mux.

Parameters:
WIDTH, 32, PC and target width in bits
RESET_PC, 32'h00000000, PC value loaded on reset
FLUSH_DEPTH, 2, number of younger instructions squashed after a taken redirect (1..7)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
bs  input  2  branch select from EX: 00 seq, 01 cond, 10 RAA, 11 BrA
ps  input  1  condition polarity from EX
z  input  1  zero flag from EX
br_valid  input  1  EX holds a valid instruction whose bs/ps/z/targets are meaningful this cycle
bra  input  WIDTH  branch target address
raa  input  WIDTH  register-A jump target
stall  input  1  pipeline hold request
imem_ready  input  1  instruction memory accepted the current fetch
pc  output  WIDTH  current fetch address (registered)
pc_valid  output  1  fetch request valid (registered)
flush  output  1  squash IF/ID contents this cycle (registered)
redirect  output  1  one-cycle pulse: pc was loaded from a branch target this cycle

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (async, any time, including mid-flush):
  - pc=RESET_PC, pc_valid=0, flush=0, redirect=0.
  - Flush counter=0, state=IDLE.
- States:
  - IDLE -> FETCH on the first rising edge after rst_n deasserts; pc_valid goes 1 on that edge.
  - FETCH -> FLUSH on a taken redirect.
  - FLUSH -> FETCH when the flush counter reaches 0.
- Taken decision, evaluated only when br_valid=1, stall=0 and flush=0:
  - bs=00: not taken.
  - bs=01: taken iff (z ^ ps)=1, i.e. PS=0 branches on Z=1 and PS=1 branches on Z=0.
  - bs=10: taken, target=raa.
  - bs=11: taken, target=bra.
  - bs=01 taken uses target=bra.
- Priority per edge: reset > stall > taken redirect > sequential advance.
- stall=1:
  - pc, pc_valid, state and flush counter hold.
  - flush and redirect are 0 that cycle.
  - br_valid is ignored; EX re-presents it.
- Taken redirect (1-cycle latency):
  - Next edge: pc<=target, redirect=1 for exactly one cycle, flush=1.
  - Counter loaded with FLUSH_DEPTH-1; state=FLUSH.
  - Redirect overrides imem_ready: the outstanding fetch is abandoned.
- FLUSH:
  - flush stays 1 for FLUSH_DEPTH consecutive non-stalled cycles total; counter decrements each non-stalled cycle.
  - Fetching continues from the target: pc advances on imem_ready.
  - br_valid is ignored, because it belongs to squashed instructions.
- Sequential advance: in FETCH or FLUSH with stall=0, no redirect and imem_ready=1, pc<=pc+1.
  - imem_ready=0: pc holds and pc_valid stays 1.
- Arithmetic: pc+1 is modulo 2^WIDTH; all-ones wraps to 0 with no flag.
- redirect in FLUSH is always 0. Back-to-back taken branches are impossible by construction, since the second is squashed.

Optional Feature:
Macro PC_SEQ_PERF_EN.
- Defined:
  - Adds output taken_cnt [15:0]: counts accepted taken redirects, saturating at 16'hFFFF.
  - Adds input cnt_clr: synchronous clear; clear wins over increment on the same edge.
  - taken_cnt resets to 0 on rst_n.
- Undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
1. Reset/sequential:
   - Stimulus: rst_n low 3 cycles, release; imem_ready=1, br_valid=0.
   - Response: pc=0 with pc_valid=0 during reset; then pc_valid=1 and pc sequence 0,1,2,3; flush and redirect never 1.
2. Conditional sweep:
   - Stimulus: bra=32'hBBBBBBBB, raa=32'hAAAAAAAA; sweep all 16 {z,ps,bs} combinations, each with one br_valid pulse from a fresh reset.
   - Response:
     - bs=00 continues pc+1.
     - bs=01 jumps to BBBBBBBB only for (z,ps)=(1,0) or (0,1).
     - bs=10 jumps to AAAAAAAA.
     - bs=11 jumps to BBBBBBBB.
     - Every jump gives redirect=1 for one cycle and flush=1 for 2 cycles.
3. Flush shadow:
   - Stimulus: taken bs=11 at pc=5, then br_valid=1 with bs=10 on each of the next 2 cycles.
   - Response: both later branches are ignored; pc=BBBBBBBB, BBBBBBBC, BBBBBBBD.
4. Stall interaction:
   - Stimulus: stall=1 for 3 cycles with br_valid=1, bs=11 held; then stall=0.
   - Response: pc frozen during the stall with no redirect; redirect fires on the first unstalled edge. A stall during FLUSH extends flush so it stays high for 2 unstalled cycles.
5. Wrap and backpressure:
   - Stimulus: redirect to 32'hFFFFFFFE; imem_ready toggles 1,0,1.
   - Response: pc=FFFFFFFE, FFFFFFFF, FFFFFFFF, 00000000.
6. Reset mid-flush / perf:
   - Stimulus: assert rst_n low asynchronously during the second flush cycle.
   - Response: all outputs return to reset values immediately, without waiting for a clock edge.
   - With PC_SEQ_PERF_EN defined: 3 taken branches give taken_cnt=3; cnt_clr gives 0.
